// File: rtl/seven_seg_capture.sv
// Seven-segment display snooper: watches a multiplexed common-anode display
// bus, waits for each digit to settle, decodes it and tracks complete frames.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 400000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_an,
  input  logic [7:0] i_segment,
  output logic [3:0] o_digit3,
  output logic [3:0] o_digit2,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit0,
  output logic [3:0] o_dp,
  output logic [3:0] o_blank,
  output logic [3:0] o_err,
  output logic       o_frame,
  output logic       o_an_err,
  output logic       o_timeout
);

  localparam int unsigned TmoW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  StableLast = 8'(STABLE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  logic [3:0] an_s1_q, an_q, an_prev_q;
  logic [7:0] seg_s1_q, seg_q, seg_prev_q;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [3:0] mask_q, mask_d, mask_set;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0] dp_q, dp_d, blank_q, blank_d, err_q, err_d;
  logic       frame_q, frame_d, an_err_q, an_err_d;
  logic       capture, multi;
  logic       changed, idle_an, one_hot;
  logic [3:0] an_low;
  logic [3:0] dec_val;
  logic       dec_blank, dec_err;

  // Two-flop synchronizer plus a one-cycle history for change detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      an_s1_q    <= 4'hF;
      an_q       <= 4'hF;
      an_prev_q  <= 4'hF;
      seg_s1_q   <= 8'hFF;
      seg_q      <= 8'hFF;
      seg_prev_q <= 8'hFF;
    end else begin
      an_s1_q    <= i_an;
      an_q       <= an_s1_q;
      an_prev_q  <= an_q;
      seg_s1_q   <= i_segment;
      seg_q      <= seg_s1_q;
      seg_prev_q <= seg_q;
    end
  end

  assign changed = {an_q, seg_q} != {an_prev_q, seg_prev_q};
  assign idle_an = an_q == 4'hF;
  assign an_low  = ~an_q;
  // Only meaningful when at least one anode is low (never in IDLE).
  assign one_hot = (an_low & (an_low - 4'd1)) == 4'd0;

  // Active-low {g..a} pattern to hex value; 7F is a blanked digit.
  always_comb begin
    dec_val   = 4'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    unique case (seg_q[6:0])
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // Settle/hold FSM: a digit is taken once per stable display period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    multi   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!idle_an) begin
          state_d = StSettle;
          cnt_d   = 8'd0;
        end
      end
      StSettle: begin
        if (idle_an) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (changed) begin
          cnt_d = 8'd0;
        end else if (cnt_q == StableLast) begin
          cnt_d   = 8'd0;
          state_d = StHold;
          capture = one_hot;
          multi   = !one_hot;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (changed) begin
          cnt_d   = 8'd0;
          state_d = idle_an ? StIdle : StSettle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Capture path: per-digit outputs, seen mask, frame and timeout tracking.
  always_comb begin
    digit_d  = digit_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    err_d    = err_q;
    mask_set = mask_q;
    mask_d   = mask_q;
    frame_d  = 1'b0;
    an_err_d = multi;
    tmo_d    = tmo_q;
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (an_low[i]) begin
          digit_d[i] = dec_val;
          dp_d[i]    = ~seg_q[7];
          blank_d[i] = dec_blank;
          err_d[i]   = dec_err;
        end
      end
      mask_set = mask_q | an_low;
      if (mask_set == 4'hF) begin
        frame_d = 1'b1;
        mask_d  = 4'h0;
      end else begin
        mask_d = mask_set;
      end
      tmo_d = '0;
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      tmo_q    <= '0;
      mask_q   <= 4'h0;
      digit_q  <= '0;
      dp_q     <= 4'h0;
      blank_q  <= 4'hF;
      err_q    <= 4'h0;
      frame_q  <= 1'b0;
      an_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      mask_q   <= mask_d;
      digit_q  <= digit_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      an_err_q <= an_err_d;
    end
  end

  assign o_digit0  = digit_q[0];
  assign o_digit1  = digit_q[1];
  assign o_digit2  = digit_q[2];
  assign o_digit3  = digit_q[3];
  assign o_dp      = dp_q;
  assign o_blank   = blank_q;
  assign o_err     = err_q;
  assign o_frame   = frame_q;
  assign o_an_err  = an_err_q;
  assign o_timeout = tmo_q == TmoMax;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_seven_seg_capture;

  logic       clk;
  logic       i_reset_n;
  logic [3:0] i_an;
  logic [7:0] i_segment;
  logic [3:0] o_digit3, o_digit2, o_digit1, o_digit0;
  logic [3:0] o_dp, o_blank, o_err;
  logic       o_frame, o_an_err, o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_cnt  = 0;
  int an_err_cnt = 0;

  logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] seg_tab [4] = '{8'h79, 8'h24, 8'h30, 8'h19};

  seven_seg_capture #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(i_reset_n),
    .i_an     (i_an),
    .i_segment(i_segment),
    .o_digit3 (o_digit3),
    .o_digit2 (o_digit2),
    .o_digit1 (o_digit1),
    .o_digit0 (o_digit0),
    .o_dp     (o_dp),
    .o_blank  (o_blank),
    .o_err    (o_err),
    .o_frame  (o_frame),
    .o_an_err (o_an_err),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_frame === 1'b1) frame_cnt++;
    if (o_an_err === 1'b1) an_err_cnt++;
  end

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
    i_an = an;
    i_segment = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_an = 4'hF;
    i_segment = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int first, input int last);
    for (int i = first; i <= last; i++) drive(an_tab[i], seg_tab[i], 10);
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({o_digit3, o_digit2, o_digit1, o_digit0} !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s_digits: got %h expected 0000", tag,
               {o_digit3, o_digit2, o_digit1, o_digit0});
    end
    n_checks++;
    if ({o_dp, o_blank, o_err} !== 12'h0F0) begin
      n_fail++;
      $display("FAIL %s_dp_blank_err: got %h expected 0f0", tag, {o_dp, o_blank, o_err});
    end
    n_checks++;
    if ({o_frame, o_an_err, o_timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_pulses: got %b expected 000", tag, {o_frame, o_an_err, o_timeout});
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_an = 4'hF;
    i_segment = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
  endtask

  task automatic test_timeout();
    i_reset_n = 1'b1;
    drive(4'hF, 8'hFF, 15);
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b expected 0", o_timeout);
    end
    drive(4'hF, 8'hFF, 10);
    n_checks++;
    if (o_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_set: got %b expected 1", o_timeout);
    end
    drive(4'hE, 8'h79, 10);
    n_checks++;
    if (o_timeout !== 1'b0 || o_digit0 !== 4'd1) begin
      n_fail++;
      $display("FAIL timeout_clear: got timeout=%b digit0=%h expected 0,1", o_timeout, o_digit0);
    end
  endtask

  task automatic test_scan();
    int f0;
    do_reset();
    f0 = frame_cnt;
    scan(0, 2);
    n_checks++;
    if (frame_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL scan_early_frame: got %0d expected 0", frame_cnt - f0);
    end
    scan(3, 3);
    drive(4'hF, 8'hFF, 4);
    n_checks++;
    if ({o_digit3, o_digit2, o_digit1, o_digit0} !== 16'h4321) begin
      n_fail++;
      $display("FAIL scan_digits: got %h expected 4321", {o_digit3, o_digit2, o_digit1, o_digit0});
    end
    n_checks++;
    if ({o_dp, o_blank, o_err} !== 12'hF00) begin
      n_fail++;
      $display("FAIL scan_dp_blank_err: got %h expected f00", {o_dp, o_blank, o_err});
    end
    n_checks++;
    if (frame_cnt - f0 !== 1) begin
      n_fail++;
      $display("FAIL scan_frame_count: got %0d expected 1", frame_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'hE, 8'h24, 2);
      drive(4'hE, 8'h00, 1);
    end
    n_checks++;
    if (o_digit0 !== 4'd0 || o_blank[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_no_capture: got digit0=%h blank0=%b expected 0,1",
               o_digit0, o_blank[0]);
    end
    drive(4'hE, 8'h24, 10);
    n_checks++;
    if (o_digit0 !== 4'd2 || o_blank[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_capture: got digit0=%h blank0=%b expected 2,0", o_digit0, o_blank[0]);
    end
  endtask

  // Runs after test_glitch: digit0 = 2 and seen mask = 0001 on entry.
  task automatic test_an_err();
    int e0, f0;
    e0 = an_err_cnt;
    f0 = frame_cnt;
    drive(4'hC, 8'h79, 6);
    drive(4'hF, 8'hFF, 4);
    n_checks++;
    if (an_err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL an_err_pulses: got %0d expected 1", an_err_cnt - e0);
    end
    n_checks++;
    if ({o_digit1, o_digit0} !== 8'h02 || o_blank[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL an_err_digits: got %h blank1=%b expected 02,1", {o_digit1, o_digit0},
               o_blank[1]);
    end
    scan(1, 2);
    n_checks++;
    if (frame_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL an_err_mask_partial: got %0d frames expected 0", frame_cnt - f0);
    end
    scan(3, 3);
    drive(4'hF, 8'hFF, 3);
    n_checks++;
    if (frame_cnt - f0 !== 1) begin
      n_fail++;
      $display("FAIL an_err_mask_frame: got %0d frames expected 1", frame_cnt - f0);
    end
  endtask

  task automatic test_blank_dp();
    int f0;
    do_reset();
    f0 = frame_cnt;
    drive(4'hE, 8'h79, 10);
    n_checks++;
    if ({o_digit0, o_dp[0], o_blank[0], o_err[0]} !== 7'b0001_100) begin
      n_fail++;
      $display("FAIL bd_first: got %b expected 0001100", {o_digit0, o_dp[0], o_blank[0], o_err[0]});
    end
    drive(4'hE, 8'hFF, 10);
    n_checks++;
    if ({o_digit0, o_dp[0], o_blank[0], o_err[0]} !== 7'b0000_010) begin
      n_fail++;
      $display("FAIL bd_blank: got %b expected 0000010", {o_digit0, o_dp[0], o_blank[0], o_err[0]});
    end
    drive(4'hE, 8'h7E, 10);
    n_checks++;
    if ({o_digit0, o_dp[0], o_blank[0], o_err[0]} !== 7'b0000_101) begin
      n_fail++;
      $display("FAIL bd_err: got %b expected 0000101", {o_digit0, o_dp[0], o_blank[0], o_err[0]});
    end
    drive(4'hE, 8'hA4, 10);
    n_checks++;
    if ({o_digit0, o_dp[0], o_blank[0], o_err[0]} !== 7'b0010_000) begin
      n_fail++;
      $display("FAIL bd_overwrite: got %b expected 0010000",
               {o_digit0, o_dp[0], o_blank[0], o_err[0]});
    end
    n_checks++;
    if (frame_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL bd_no_frame: got %0d expected 0", frame_cnt - f0);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    do_reset();
    scan(0, 2);
    drive(4'h7, 8'h19, 2);
    i_reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    f0 = frame_cnt;
    drive(4'hF, 8'hFF, 3);
    scan(3, 3);
    drive(4'hF, 8'hFF, 3);
    n_checks++;
    if (frame_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL midreset_mask_kept: got %0d frames expected 0", frame_cnt - f0);
    end
    scan(0, 3);
    drive(4'hF, 8'hFF, 3);
    n_checks++;
    if (frame_cnt - f0 !== 1) begin
      n_fail++;
      $display("FAIL midreset_frame: got %0d frames expected 1", frame_cnt - f0);
    end
    n_checks++;
    if ({o_digit3, o_digit2, o_digit1, o_digit0} !== 16'h4321) begin
      n_fail++;
      $display("FAIL midreset_digits: got %h expected 4321",
               {o_digit3, o_digit2, o_digit1, o_digit0});
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_scan();
    test_glitch();
    test_an_err();
    test_blank_dp();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
